// File: rtl/note_select.sv
// ----------------------------------------------------------------------------
// note_select
//   Turns debounced key levels into one monophonic note for the synth voice.
//   The most recently pressed key wins. When the sounding key is released
//   while other keys are still held, the note falls back to the lowest held
//   key. The octave is stepped by the debounced octave button pulses.
//
// Ports
//   clk     in   1      system clock
//   rst     in   1      synchronous reset, active-high
//   keys    in   NKEYS  debounced key levels, 1 = held
//   oct_up  in   1      one-tick pulse, octave +1 (saturating)
//   oct_dn  in   1      one-tick pulse, octave -1 (saturating)
//   note    out  NW     index of the sounding key
//   octave  out  3      current octave
//   gate    out  1      1 while a note sounds
//   trig    out  1      one-cycle pulse on every note start or note change
// ----------------------------------------------------------------------------
module note_select #(
  parameter  int NKEYS    = 8,
  parameter  int OCT_MIN  = 0,
  parameter  int OCT_MAX  = 6,
  parameter  int OCT_INIT = 3,
  localparam int NW       = $clog2(NKEYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] keys,
  input  logic             oct_up,
  input  logic             oct_dn,
  output logic [NW-1:0]    note,
  output logic [2:0]       octave,
  output logic             gate,
  output logic             trig
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           state_q,  state_d;
  logic [NKEYS-1:0] keys_q;
  logic [NW-1:0]    note_q,   note_d;
  logic [2:0]       octave_q, octave_d;
  logic             gate_q,   gate_d;
  logic             trig_q,   trig_d;

  logic [NKEYS-1:0] rise_s;
  logic             cur_held_s;

  // Lowest set index wins; an all-zero vector encodes to 0 (never used).
  function automatic logic [NW-1:0] lowest_index(input logic [NKEYS-1:0] vec);
    logic [NW-1:0] idx;
    idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = NW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign rise_s     = keys & ~keys_q;
  assign cur_held_s = keys[note_q];

  // Note/gate/trig selection: a new press always wins, then fallback, then release.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    gate_d  = gate_q;
    trig_d  = 1'b0;
    if (rise_s != '0) begin
      // Covers a simultaneous release of the current key and press of another.
      note_d  = lowest_index(rise_s);
      trig_d  = 1'b1;
      gate_d  = 1'b1;
      state_d = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (keys == '0) begin
            gate_d  = 1'b0;
            state_d = IDLE;
          end else if (!cur_held_s) begin
            note_d = lowest_index(keys);
            trig_d = 1'b1;
          end else begin
            note_d = note_q;
          end
        end
        IDLE: begin
          gate_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          gate_d  = 1'b0;
        end
      endcase
    end
  end

  // Octave stepping; both buttons together cancel out.
  always_comb begin
    octave_d = octave_q;
    if (oct_up && !oct_dn && (octave_q < 3'(OCT_MAX))) begin
      octave_d = octave_q + 3'd1;
    end else if (oct_dn && !oct_up && (octave_q > 3'(OCT_MIN))) begin
      octave_d = octave_q - 3'd1;
    end else begin
      octave_d = octave_q;
    end
  end

  // State and output registers; reset clears keys_q so held keys retrigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      keys_q   <= '0;
      note_q   <= '0;
      octave_q <= 3'(OCT_INIT);
      gate_q   <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      keys_q   <= keys;
      note_q   <= note_d;
      octave_q <= octave_d;
      gate_q   <= gate_d;
      trig_q   <= trig_d;
    end
  end

  assign note   = note_q;
  assign octave = octave_q;
  assign gate   = gate_q;
  assign trig   = trig_q;

endmodule

// File: tb/tb_note_select.sv
module tb_note_select;

  logic       clk;
  logic       rst;
  logic [7:0] keys;
  logic       oct_up;
  logic       oct_dn;
  logic [2:0] note;
  logic [2:0] octave;
  logic       gate;
  logic       trig;

  int vectors;
  int miscompares;

  note_select #(
    .NKEYS   (8),
    .OCT_MIN (0),
    .OCT_MAX (6),
    .OCT_INIT(3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .keys  (keys),
    .oct_up(oct_up),
    .oct_dn(oct_dn),
    .note  (note),
    .octave(octave),
    .gate  (gate),
    .trig  (trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_note,
                           input logic [2:0] e_oct, input logic e_gate,
                           input logic e_trig);
    check({tag, ".note"},   {5'd0, note},   {5'd0, e_note});
    check({tag, ".octave"}, {5'd0, octave}, {5'd0, e_oct});
    check({tag, ".gate"},   {7'd0, gate},   {7'd0, e_gate});
    check({tag, ".trig"},   {7'd0, trig},   {7'd0, e_trig});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    keys   = 8'h00;
    oct_up = 1'b0;
    oct_dn = 1'b0;
    tick();
    tick();
    check_all("reset", 3'd0, 3'd3, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_all("idle", 3'd0, 3'd3, 1'b0, 1'b0);

    // 1. single key press
    keys = 8'h04;
    tick(); check_all("t1.press", 3'd2, 3'd3, 1'b1, 1'b1);
    tick(); check_all("t1.hold",  3'd2, 3'd3, 1'b1, 1'b0);

    // 2. last-pressed priority and fallback
    keys = 8'h24;
    tick(); check_all("t2.press5",  3'd5, 3'd3, 1'b1, 1'b1);
    tick(); check_all("t2.hold5",   3'd5, 3'd3, 1'b1, 1'b0);
    keys = 8'h04;
    tick(); check_all("t2.fall2",   3'd2, 3'd3, 1'b1, 1'b1);
    tick(); check_all("t2.hold2",   3'd2, 3'd3, 1'b1, 1'b0);
    keys = 8'h00;
    tick(); check_all("t2.release", 3'd2, 3'd3, 1'b0, 1'b0);
    tick(); check_all("t2.idle",    3'd2, 3'd3, 1'b0, 1'b0);

    // 3. two keys at once, release non-current key
    keys = 8'h12;
    tick(); check_all("t3.press",  3'd1, 3'd3, 1'b1, 1'b1);
    tick(); check_all("t3.hold",   3'd1, 3'd3, 1'b1, 1'b0);
    keys = 8'h02;
    tick(); check_all("t3.rel4",   3'd1, 3'd3, 1'b1, 1'b0);
    keys = 8'h00;
    tick(); check_all("t3.relall", 3'd1, 3'd3, 1'b0, 1'b0);

    // fallback picks lowest held index
    keys = 8'h0A;
    tick(); check_all("fb.press13", 3'd1, 3'd3, 1'b1, 1'b1);
    keys = 8'h4A;
    tick(); check_all("fb.press6",  3'd6, 3'd3, 1'b1, 1'b1);
    keys = 8'h0A;
    tick(); check_all("fb.rel6",    3'd1, 3'd3, 1'b1, 1'b1);
    tick(); check_all("fb.hold",    3'd1, 3'd3, 1'b1, 1'b0);
    keys = 8'h08;
    tick(); check_all("fb.rel1",    3'd3, 3'd3, 1'b1, 1'b1);
    keys = 8'h00;
    tick(); check_all("fb.relall",  3'd3, 3'd3, 1'b0, 1'b0);

    // 4. octave saturation
    oct_up = 1'b1;
    tick(); check_all("t4.up1", 3'd3, 3'd4, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    check_all("t4.up5sat", 3'd3, 3'd6, 1'b0, 1'b0);
    oct_up = 1'b0;
    oct_dn = 1'b1;
    tick(); check_all("t4.dn1", 3'd3, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check_all("t4.dn8sat", 3'd3, 3'd0, 1'b0, 1'b0);
    oct_up = 1'b1;
    tick(); check_all("t4.both0", 3'd3, 3'd0, 1'b0, 1'b0);
    oct_dn = 1'b0;
    tick(); check_all("t4.up", 3'd3, 3'd1, 1'b0, 1'b0);
    oct_dn = 1'b1;
    tick(); check_all("t4.both1", 3'd3, 3'd1, 1'b0, 1'b0);
    oct_up = 1'b0;
    oct_dn = 1'b0;

    // octave change while a note plays leaves note/gate/trig alone
    keys = 8'h01;
    tick(); check_all("oc.press0", 3'd0, 3'd1, 1'b1, 1'b1);
    oct_up = 1'b1;
    tick(); check_all("oc.up",     3'd0, 3'd2, 1'b1, 1'b0);
    oct_up = 1'b0;
    keys = 8'h00;
    tick(); check_all("oc.rel",    3'd0, 3'd2, 1'b0, 1'b0);

    // 5. reset mid-note, held key retriggers afterwards
    keys = 8'h08;
    tick(); check_all("t5.press3", 3'd3, 3'd2, 1'b1, 1'b1);
    tick(); check_all("t5.hold",   3'd3, 3'd2, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); check_all("t5.rst",    3'd0, 3'd3, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); check_all("t5.retrig", 3'd3, 3'd3, 1'b1, 1'b1);
    tick(); check_all("t5.hold2",  3'd3, 3'd3, 1'b1, 1'b0);

    // 6. release current and press another on the same edge
    keys = 8'h40;
    tick(); check_all("t6.swap", 3'd6, 3'd3, 1'b1, 1'b1);
    tick(); check_all("t6.hold", 3'd6, 3'd3, 1'b1, 1'b0);
    tick(); check_all("t6.hold2", 3'd6, 3'd3, 1'b1, 1'b0);
    keys = 8'h00;
    tick(); check_all("t6.rel", 3'd6, 3'd3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
